// File: rtl/btn_seq_pkg.sv
// Shared types and constants for the button-sequence pulse generator.
package btn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    LOCK  = 2'd3
  } state_e;

  localparam int unsigned TIMER_W = 8;

  localparam logic [1:0] DEF_START_MASK   = 2'b11;
  localparam logic [1:0] DEF_CONFIRM_MASK = 2'b10;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the WAIT and LOCK phases.
module seq_timer
  import btn_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero_c
);

  logic [TIMER_W-1:0] cnt_q;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/btn_seq_pulse.sv
// Start/confirm button-sequence pulse generator with programmable wait and
// lockout, modifier-advanced output, abort flag and saturating hit counter.
module btn_seq_pulse
  import btn_seq_pkg::*;
#(
  parameter int unsigned           N_BTN        = 2,
  parameter logic [N_BTN-1:0]      START_MASK   = N_BTN'(DEF_START_MASK),
  parameter logic [N_BTN-1:0]      CONFIRM_MASK = N_BTN'(DEF_CONFIRM_MASK),
  parameter int unsigned           DELAY        = 2,
  parameter int unsigned           LOCKOUT      = 4,
  parameter int unsigned           CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_BTN-1:0] trig,
  input  logic             mod,
  output logic             outp,
  output logic             busy,
  output logic             abort,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q;
  state_e             state_nxt;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;
  logic               hit_inc;
  logic               start_ok;
  logic               confirm_ok;

  assign start_ok   = en && $onehot(trig) && (|(trig & START_MASK));
  assign confirm_ok = $onehot(trig) && (|(trig & CONFIRM_MASK));

  seq_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state, timer control and combinational output decode.
  always_comb begin
    state_nxt = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    hit_inc   = 1'b0;
    outp      = 1'b0;
    busy      = 1'b0;
    abort     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_nxt = WAIT;
          tmr_load  = 1'b1;
          tmr_val   = TIMER_W'(DELAY - 1);
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (tmr_zero) begin
          state_nxt = CHECK;
          outp      = mod;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CHECK: begin
        busy = 1'b1;
        outp = 1'b1;
        if (confirm_ok) begin
          state_nxt = LOCK;
          tmr_load  = 1'b1;
          tmr_val   = TIMER_W'(LOCKOUT - 1);
          hit_inc   = 1'b1;
        end else begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      LOCK: begin
        busy = 1'b1;
        if (tmr_zero) begin
          state_nxt = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reset silences every flag immediately, not only after the edge.
    if (rst) begin
      outp  = 1'b0;
      busy  = 1'b0;
      abort = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (hit_inc && (hit_cnt != CNT_MAX)) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_btn_seq_pulse.sv
// Directed scoreboard bench: default-parameter instance (a) and a short
// DELAY=1 / LOCKOUT=1 / CNT_W=2 instance (b).
module tb_btn_seq_pulse;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, mod_a;
  logic [1:0] trig_a;
  logic       outp_a, busy_a, abort_a;
  logic [7:0] hit_a;

  logic       rst_b, en_b, mod_b;
  logic [1:0] trig_b;
  logic       outp_b, busy_b, abort_b;
  logic [1:0] hit_b;

  btn_seq_pulse dut_a (
    .clk     (clk),
    .rst     (rst_a),
    .en      (en_a),
    .trig    (trig_a),
    .mod     (mod_a),
    .outp    (outp_a),
    .busy    (busy_a),
    .abort   (abort_a),
    .hit_cnt (hit_a)
  );

  btn_seq_pulse #(
    .DELAY   (1),
    .LOCKOUT (1),
    .CNT_W   (2)
  ) dut_b (
    .clk     (clk),
    .rst     (rst_b),
    .en      (en_b),
    .trig    (trig_b),
    .mod     (mod_b),
    .outp    (outp_b),
    .busy    (busy_b),
    .abort   (abort_b),
    .hit_cnt (hit_b)
  );

  typedef struct {
    string      tag;
    bit         sel;
    logic       outp;
    logic       busy;
    logic       abort;
    logic [7:0] hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_front();
    exp_t e;
    logic       ao, ab, aa;
    logic [7:0] ah;
    n_tests++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      ao = e.sel ? outp_b  : outp_a;
      ab = e.sel ? busy_b  : busy_a;
      aa = e.sel ? abort_b : abort_a;
      ah = e.sel ? {6'b0, hit_b} : hit_a;
      n_tests++;
      assert (ao === e.outp) else begin
        n_fail++;
        $error("FAIL %s.outp observed=%b expected=%b", e.tag, ao, e.outp);
      end
      n_tests++;
      assert (ab === e.busy) else begin
        n_fail++;
        $error("FAIL %s.busy observed=%b expected=%b", e.tag, ab, e.busy);
      end
      n_tests++;
      assert (aa === e.abort) else begin
        n_fail++;
        $error("FAIL %s.abort observed=%b expected=%b", e.tag, aa, e.abort);
      end
      n_tests++;
      assert (ah === e.hit) else begin
        n_fail++;
        $error("FAIL %s.hit_cnt observed=%0d expected=%0d", e.tag, ah, e.hit);
      end
    end
  endtask

  // Drive one cycle of inputs, record expectations, check mid-cycle, then clock.
  task automatic step(input string tag, input bit sel,
                      input logic r, input logic e, input logic [1:0] t, input logic m,
                      input logic eo, input logic eb, input logic ea, input logic [7:0] eh);
    exp_t x;
    if (sel) begin
      rst_b = r; en_b = e; trig_b = t; mod_b = m;
    end else begin
      rst_a = r; en_a = e; trig_a = t; mod_a = m;
    end
    x.tag = tag; x.sel = sel; x.outp = eo; x.busy = eb; x.abort = ea; x.hit = eh;
    exp_q.push_back(x);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; trig_a = 2'b00; mod_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; trig_b = 2'b00; mod_b = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a valid start present: everything quiet.
    step("rst_gate", 0, 1, 1, 2'b01, 1, 0, 0, 0, 8'd0);

    // Confirmed sequence, mod low.
    step("s1_c0",   0, 0, 1, 2'b01, 0, 0, 0, 0, 8'd0);
    step("s1_w1",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd0);
    step("s1_w2",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd0);
    step("s1_chk",  0, 0, 1, 2'b10, 0, 1, 1, 0, 8'd0);
    step("s1_l1",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd1);
    step("s1_l2",   0, 0, 1, 2'b01, 1, 0, 1, 0, 8'd1);
    step("s1_l3",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd1);
    step("s1_l4",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd1);
    step("s1_idle", 0, 0, 1, 2'b00, 1, 0, 0, 0, 8'd1);

    // Confirmed sequence with mod advancing outp into the last WAIT cycle.
    step("s2_c0",   0, 0, 1, 2'b01, 0, 0, 0, 0, 8'd1);
    step("s2_w1",   0, 0, 1, 2'b00, 1, 0, 1, 0, 8'd1);
    step("s2_w2",   0, 0, 1, 2'b00, 1, 1, 1, 0, 8'd1);
    step("s2_chk",  0, 0, 1, 2'b10, 1, 1, 1, 0, 8'd1);
    step("s2_l1",   0, 0, 1, 2'b00, 1, 0, 1, 0, 8'd2);
    step("s2_l2",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s2_l3",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s2_l4",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s2_idle", 0, 0, 1, 2'b00, 0, 0, 0, 0, 8'd2);

    // No confirm at CHECK: abort, back to IDLE, counter unchanged.
    step("s3_c0",   0, 0, 1, 2'b01, 0, 0, 0, 0, 8'd2);
    step("s3_w1",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s3_w2",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s3_chk",  0, 0, 1, 2'b00, 0, 1, 1, 1, 8'd2);
    step("s3_idle", 0, 0, 1, 2'b00, 0, 0, 0, 0, 8'd2);

    // Start on b2, multi-hot at CHECK is not a confirm.
    step("s3b_c0",  0, 0, 1, 2'b10, 0, 0, 0, 0, 8'd2);
    step("s3b_w1",  0, 0, 1, 2'b10, 0, 0, 1, 0, 8'd2);
    step("s3b_w2",  0, 0, 1, 2'b10, 0, 0, 1, 0, 8'd2);
    step("s3b_chk", 0, 0, 1, 2'b11, 0, 1, 1, 1, 8'd2);
    step("s3b_idl", 0, 0, 1, 2'b00, 0, 0, 0, 0, 8'd2);

    // One-hot but outside the confirm mask.
    step("s3c_c0",  0, 0, 1, 2'b01, 0, 0, 0, 0, 8'd2);
    step("s3c_w1",  0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s3c_w2",  0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s3c_chk", 0, 0, 1, 2'b01, 0, 1, 1, 1, 8'd2);
    step("s3c_idl", 0, 0, 1, 2'b00, 0, 0, 0, 0, 8'd2);

    // Invalid starts: multi-hot, then enable low.
    step("s4_multi", 0, 0, 1, 2'b11, 0, 0, 0, 0, 8'd2);
    step("s4_en0",   0, 0, 0, 2'b01, 0, 0, 0, 0, 8'd2);
    step("s4_zero",  0, 0, 1, 2'b00, 0, 0, 0, 0, 8'd2);

    // Reset during LOCK, then an immediate restart.
    step("s6_c0",   0, 0, 1, 2'b01, 0, 0, 0, 0, 8'd2);
    step("s6_w1",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s6_w2",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd2);
    step("s6_chk",  0, 0, 1, 2'b10, 0, 1, 1, 0, 8'd2);
    step("s6_l1",   0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd3);
    step("s6_rst",  0, 1, 1, 2'b00, 1, 0, 0, 0, 8'd3);
    step("s6_re0",  0, 0, 1, 2'b01, 0, 0, 0, 0, 8'd0);
    step("s6_w1b",  0, 0, 1, 2'b00, 0, 0, 1, 0, 8'd0);
    step("s6_w2b",  0, 0, 1, 2'b00, 1, 1, 1, 0, 8'd0);
    step("s6_chkb", 0, 0, 1, 2'b00, 0, 1, 1, 1, 8'd0);
    step("s6_idle", 0, 0, 1, 2'b00, 0, 0, 0, 0, 8'd0);

    // Short instance: five back-to-back confirmed sequences, counter saturates at 3.
    step("b_rst", 1, 1, 1, 2'b01, 1, 0, 0, 0, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] hb0, hb1;
      logic       m;
      hb0 = 8'((k - 1) > 3 ? 3 : (k - 1));
      hb1 = 8'(k > 3 ? 3 : k);
      m   = (k == 2);
      step($sformatf("b%0d_idle", k), 1, 0, 1, 2'b01, 0, 0, 0, 0, hb0);
      step($sformatf("b%0d_wait", k), 1, 0, 1, 2'b00, m, m, 1, 0, hb0);
      step($sformatf("b%0d_chk",  k), 1, 0, 1, 2'b10, 0, 1, 1, 0, hb0);
      step($sformatf("b%0d_lock", k), 1, 0, 1, 2'b01, 0, 0, 1, 0, hb1);
    end
    step("b_end", 1, 0, 1, 2'b00, 0, 0, 0, 0, 8'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
